hwpe_ctrl_uloop_nd: RTL and testbench

Parametrised microcode nested-loop offset generator for HWPE streamers. It executes one micro-instruction per cycle over NB_LOOPS nested loops and a file of NB_REG writable accumulators plus NB_RO_REG read-only registers. Results are emitted as beats on a valid/ready output port with backpressure, a last flag and a done pulse. It sits between the HWPE controller FSM and the streamer address generators.

---
 rtl/hwpe_ctrl_uloop_nd_if.sv | 24 ++
 rtl/hwpe_ctrl_uloop_nd.sv | 219 +++++++++++++++++++++
 tb/tb_hwpe_ctrl_uloop_nd.sv | 245 ++++++++++++++++++++++++
 3 files changed

// File: rtl/hwpe_ctrl_uloop_nd_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | hwpe_ctrl_uloop_nd_if : beat port of the nested-loop offset generator       |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
interface hwpe_ctrl_uloop_nd_if #(
    parameter int NB_LOOPS  = 4,
    parameter int NB_REG    = 4,
    parameter int REG_WIDTH = 32,
    parameter int CNT_WIDTH = 16
);
    localparam int LW = $clog2(NB_LOOPS);

    logic                          valid;
    logic                          ready;
    logic                          last;
    logic [NB_REG*REG_WIDTH-1:0]   offs;
    logic [NB_LOOPS*CNT_WIDTH-1:0] idx;
    logic [LW-1:0]                 loop;

    modport master (output valid, last, offs, idx, loop, input  ready);
    modport slave  (input  valid, last, offs, idx, loop, output ready);
endinterface
`default_nettype wire

// File: rtl/hwpe_ctrl_uloop_nd.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | hwpe_ctrl_uloop_nd : microcode nested-loop offset generator for streamers   |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
module hwpe_ctrl_uloop_nd #(
    parameter int LENGTH    = 16,
    parameter int NB_LOOPS  = 4,
    parameter int NB_REG    = 4,
    parameter int NB_RO_REG = 8,
    parameter int REG_WIDTH = 32,
    parameter int CNT_WIDTH = 16,
    localparam int AW = $clog2(LENGTH),
    localparam int LW = $clog2(NB_LOOPS),
    localparam int RW = $clog2(NB_REG),
    localparam int BW = $clog2(NB_REG + NB_RO_REG),
    localparam int IW = 2 + RW + BW
) (
    input  wire logic                           clk_i,
    input  wire logic                           rst_i,
    input  wire logic                           clear_i,
    input  wire logic                           start_i,
    input  wire logic [LENGTH*IW-1:0]           code_i,
    input  wire logic [NB_LOOPS*AW-1:0]         loop_addr_i,
    input  wire logic [NB_LOOPS*AW-1:0]         loop_last_op_i,
    input  wire logic [NB_LOOPS*CNT_WIDTH-1:0]  range_i,
    input  wire logic [NB_RO_REG*REG_WIDTH-1:0] registers_read_i,
    hwpe_ctrl_uloop_nd_if.master                beat,
    output logic                                busy_o,
    output logic                                done_o
);

    localparam logic [1:0] C_OP_MOV = 2'b00;
    localparam logic [1:0] C_OP_ADD = 2'b01;
    localparam logic [1:0] C_OP_SUB = 2'b10;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_HOLD = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t                 r_state;
    state_t                 w_state_nxt;

    logic [REG_WIDTH-1:0]   r_regs [NB_REG];
    logic [CNT_WIDTH-1:0]   r_idx  [NB_LOOPS];
    logic [LW-1:0]          r_curr_loop;
    logic [AW-1:0]          r_curr_op;

    logic [AW-1:0]          w_loop_addr [NB_LOOPS];
    logic [AW-1:0]          w_last_op   [NB_LOOPS];
    logic [CNT_WIDTH-1:0]   w_range     [NB_LOOPS];
    logic [IW-1:0]          w_code      [LENGTH];
    logic [REG_WIDTH-1:0]   w_ro        [NB_RO_REG];

    logic [AW-1:0]          w_addr;
    logic [IW-1:0]          w_instr;
    logic [1:0]             w_op;
    logic [RW-1:0]          w_a;
    logic [BW-1:0]          w_b;
    logic [REG_WIDTH-1:0]   w_operand;
    logic [REG_WIDTH-1:0]   w_result;
    logic                   w_write;
    logic                   w_body_more;
    logic                   w_all_max;
    logic                   w_last;
    logic [LW-1:0]          w_carry;
    logic                   w_accept;

    // ---------------- configuration unpacking ----------------
    generate
        for (genvar gj = 0; gj < NB_LOOPS; gj++) begin : g_loop_cfg
            assign w_loop_addr[gj] = loop_addr_i[gj*AW +: AW];
            assign w_last_op[gj]   = loop_last_op_i[gj*AW +: AW];
            assign w_range[gj]     = range_i[gj*CNT_WIDTH +: CNT_WIDTH];
        end
        for (genvar gk = 0; gk < LENGTH; gk++) begin : g_code
            assign w_code[gk] = code_i[gk*IW +: IW];
        end
        for (genvar gr = 0; gr < NB_RO_REG; gr++) begin : g_ro
            assign w_ro[gr] = registers_read_i[gr*REG_WIDTH +: REG_WIDTH];
        end
    endgenerate

    // ---------------- instruction fetch and execute ----------------
    assign w_addr      = w_loop_addr[r_curr_loop] + r_curr_op;
    assign w_instr     = w_code[w_addr];
    assign w_op        = w_instr[IW-1 -: 2];
    assign w_a         = w_instr[BW +: RW];
    assign w_b         = w_instr[BW-1:0];
    assign w_body_more = (r_curr_op < w_last_op[r_curr_loop]);

    // Unified read space: writable file, then read-only inputs, then zeros.
    always_comb begin
        w_operand = '0;
        for (int k = 0; k < NB_REG; k++) begin
            if (w_b == BW'(k)) w_operand = r_regs[k];
        end
        for (int k = 0; k < NB_RO_REG; k++) begin
            if (w_b == BW'(NB_REG + k)) w_operand = w_ro[k];
        end
    end

    always_comb begin
        w_result = r_regs[w_a];
        w_write  = 1'b1;
        case (w_op)
            C_OP_MOV: w_result = w_operand;
            C_OP_ADD: w_result = r_regs[w_a] + w_operand;
            C_OP_SUB: w_result = r_regs[w_a] - w_operand;
            default:  w_write  = 1'b0;
        endcase
    end

    // ---------------- loop bookkeeping ----------------
    always_comb begin
        w_all_max = 1'b1;
        for (int j = 0; j < NB_LOOPS; j++) begin
            if (r_idx[j] != w_range[j]) w_all_max = 1'b0;
        end
    end

    always_comb begin
        w_carry = '0;
        for (int j = NB_LOOPS - 1; j >= 0; j--) begin
            if (r_idx[j] < w_range[j]) w_carry = LW'(j);
        end
    end

    // An outer body is always followed by the innermost body at the same
    // indices, so the program only ends after an innermost-loop beat.
    assign w_last   = w_all_max && (r_curr_loop == '0);
    assign w_accept = (r_state == S_HOLD) && beat.ready;

    // ---------------- FSM ----------------
    always_ff @(posedge clk_i) begin
        if (rst_i || clear_i) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: if (start_i) w_state_nxt = S_RUN;
            S_RUN:  if (!w_body_more) w_state_nxt = S_HOLD;
            S_HOLD: if (beat.ready) w_state_nxt = w_last ? S_DONE : S_RUN;
            S_DONE: w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // ---------------- datapath registers ----------------
    always_ff @(posedge clk_i) begin
        if (rst_i || clear_i) begin
            for (int k = 0; k < NB_REG; k++)   r_regs[k] <= '0;
            for (int j = 0; j < NB_LOOPS; j++) r_idx[j]  <= '0;
            r_curr_loop <= '0;
            r_curr_op   <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start_i) begin
                        for (int k = 0; k < NB_REG; k++)   r_regs[k] <= '0;
                        for (int j = 0; j < NB_LOOPS; j++) r_idx[j]  <= '0;
                        r_curr_loop <= '0;
                        r_curr_op   <= '0;
                    end
                end
                S_RUN: begin
                    if (w_write) r_regs[w_a] <= w_result;
                    if (w_body_more) r_curr_op <= r_curr_op + 1'b1;
                end
                S_HOLD: begin
                    if (w_accept && !w_last) begin
                        r_curr_op <= '0;
                        if (r_curr_loop != '0) begin
                            r_curr_loop <= '0;
                        end else begin
                            for (int j = 0; j < NB_LOOPS; j++) begin
                                if (LW'(j) == w_carry)     r_idx[j] <= r_idx[j] + 1'b1;
                                else if (LW'(j) < w_carry) r_idx[j] <= '0;
                            end
                            r_curr_loop <= w_carry;
                        end
                    end
                end
                S_DONE: begin
                    for (int j = 0; j < NB_LOOPS; j++) r_idx[j] <= '0;
                    r_curr_loop <= '0;
                    r_curr_op   <= '0;
                end
                default: ;
            endcase
        end
    end

    // ---------------- outputs ----------------
    generate
        for (genvar gk = 0; gk < NB_REG; gk++) begin : g_offs
            assign beat.offs[gk*REG_WIDTH +: REG_WIDTH] = r_regs[gk];
        end
        for (genvar gj = 0; gj < NB_LOOPS; gj++) begin : g_idx
            assign beat.idx[gj*CNT_WIDTH +: CNT_WIDTH] = r_idx[gj];
        end
    endgenerate

    assign beat.valid = (r_state == S_HOLD);
    assign beat.last  = (r_state == S_HOLD) && w_last;
    assign beat.loop  = r_curr_loop;
    assign busy_o     = (r_state != S_IDLE);
    assign done_o     = (r_state == S_DONE);

endmodule
`default_nettype wire

// File: tb/tb_hwpe_ctrl_uloop_nd.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_hwpe_ctrl_uloop_nd : directed scoreboard bench for hwpe_ctrl_uloop_nd    |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
module tb_hwpe_ctrl_uloop_nd;
    localparam int LENGTH = 16, NB_LOOPS = 4, NB_REG = 4, NB_RO_REG = 8;
    localparam int REG_WIDTH = 32, CNT_WIDTH = 16;
    localparam int AW = 4, IW = 8;

    logic clk = 1'b0, rst = 1'b1, clear = 1'b0, start = 1'b0, ready = 1'b0;
    logic busy, done;
    logic [LENGTH*IW-1:0]           code;
    logic [NB_LOOPS*AW-1:0]         loop_addr, last_op;
    logic [NB_LOOPS*CNT_WIDTH-1:0]  range_v;
    logic [NB_RO_REG*REG_WIDTH-1:0] ro;

    int n_checks = 0;
    int n_err    = 0;

    typedef struct {
        logic [1:0]   loop;
        logic [63:0]  idx;
        logic [127:0] offs;
        logic         last;
    } beat_t;
    beat_t sb[$];

    hwpe_ctrl_uloop_nd_if #(.NB_LOOPS(NB_LOOPS), .NB_REG(NB_REG),
                            .REG_WIDTH(REG_WIDTH), .CNT_WIDTH(CNT_WIDTH)) beat_if ();
    assign beat_if.ready = ready;

    hwpe_ctrl_uloop_nd #(
        .LENGTH(LENGTH), .NB_LOOPS(NB_LOOPS), .NB_REG(NB_REG),
        .NB_RO_REG(NB_RO_REG), .REG_WIDTH(REG_WIDTH), .CNT_WIDTH(CNT_WIDTH)
    ) dut (
        .clk_i(clk), .rst_i(rst), .clear_i(clear), .start_i(start),
        .code_i(code), .loop_addr_i(loop_addr), .loop_last_op_i(last_op),
        .range_i(range_v), .registers_read_i(ro),
        .beat(beat_if), .busy_o(busy), .done_o(done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] ins(input logic [1:0] op, input logic [1:0] a, input logic [3:0] b);
        return {op, a, b};
    endfunction

    function automatic void push_beat(input logic [1:0] lp, input logic [15:0] i1, input logic [15:0] i0,
                                      input logic [31:0] r0, input logic [31:0] r1, input logic lst);
        beat_t b;
        b.loop = lp;
        b.idx  = {32'h0, i1, i0};
        b.offs = {64'h0, r1, r0};
        b.last = lst;
        sb.push_back(b);
    endfunction

    task automatic push_two_loop();
        push_beat(0, 0, 0,   4,   0, 0);
        push_beat(0, 0, 1,   8,   0, 0);
        push_beat(0, 0, 2,  12,   0, 0);
        push_beat(1, 1, 0, 100, 100, 0);
        push_beat(0, 1, 0, 104, 100, 0);
        push_beat(0, 1, 1, 108, 100, 0);
        push_beat(0, 1, 2, 112, 100, 1);
    endtask

    task automatic setup_two_loop();
        code = '0; loop_addr = '0; last_op = '0; range_v = '0; ro = '0;
        code[0*IW +: IW] = ins(2'b01, 2'd0, 4'd4);   // r0 += ro0
        code[1*IW +: IW] = ins(2'b01, 2'd1, 4'd5);   // r1 += ro1
        code[2*IW +: IW] = ins(2'b00, 2'd0, 4'd1);   // r0 <= r1
        loop_addr[1*AW +: AW] = 4'd1;
        last_op[1*AW +: AW]   = 4'd1;
        range_v[0 +: 16]  = 16'd2;
        range_v[16 +: 16] = 16'd1;
        ro[0 +: 32]  = 32'd4;
        ro[32 +: 32] = 32'd100;
    endtask

    task automatic start_prog();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_valid"}, beat_if.valid, 0);
        chk({tag, "_last"},  beat_if.last,  0);
        chk({tag, "_busy"},  busy, 0);
        chk({tag, "_done"},  done, 0);
        chk({tag, "_offs"},  beat_if.offs, 0);
        chk({tag, "_idx"},   beat_if.idx,  0);
        chk({tag, "_loop"},  beat_if.loop, 0);
    endtask

    task automatic wait_valid();
        int g = 0;
        while (!beat_if.valid && g < 50) begin
            @(negedge clk);
            g++;
        end
        chk("wait_valid", beat_if.valid, 1);
    endtask

    // Accepts beats against the scoreboard, optionally stalling one of them.
    task automatic drain(input int stall_at, input int stall_len);
        int    beats = 0, stalled = 0, guard = 0;
        bit    seen_last = 0;
        beat_t e;
        while (!seen_last && guard < 400) begin
            if (beat_if.valid && sb.size() != 0) begin
                e = sb[0];
                if (beats == stall_at && stalled < stall_len) begin
                    ready = 1'b0;
                    chk("stall_offs", beat_if.offs, e.offs);
                    chk("stall_idx",  beat_if.idx,  e.idx);
                    stalled++;
                end else begin
                    ready = 1'b1;
                    e = sb.pop_front();
                    chk($sformatf("beat%0d_loop", beats), beat_if.loop, e.loop);
                    chk($sformatf("beat%0d_idx",  beats), beat_if.idx,  e.idx);
                    chk($sformatf("beat%0d_offs", beats), beat_if.offs, e.offs);
                    chk($sformatf("beat%0d_last", beats), beat_if.last, e.last);
                    beats++;
                    if (e.last) seen_last = 1;
                end
            end else begin
                ready = 1'b1;
                chk("valid_dropped_in_stall", (stalled > 0 && stalled < stall_len), 0);
                chk("unexpected_beat", beat_if.valid, 0);
            end
            @(negedge clk);
            guard++;
        end
        chk("drain_completed", seen_last, 1);
        ready = 1'b0;
        chk("done_pulse", done, 1);
        chk("busy_at_done", busy, 1);
        @(negedge clk);
        chk("done_fall", done, 0);
        chk("busy_fall", busy, 0);
        chk("sb_empty", sb.size(), 0);
        sb.delete();
    endtask

    initial begin
        code = '0; loop_addr = '0; last_op = '0; range_v = '0; ro = '0;
        // 1. reset and idle
        repeat (3) @(negedge clk);
        rst = 1'b0;
        ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            check_zero("idle");
            @(negedge clk);
        end
        ready = 1'b0;

        // 2. two-loop program with ready held high
        setup_two_loop();
        push_two_loop();
        ready = 1'b1;
        start_prog();
        drain(-1, 0);

        // 3. backpressure on the third beat
        push_two_loop();
        start_prog();
        drain(2, 10);

        // 4. address wrap, modulo subtraction, out-of-range read
        code = '0; loop_addr = '0; last_op = '0; range_v = '0;
        ro = {32'd5, 32'd5, 32'd5, 32'd5, 32'd9, 32'd7, 32'd100, 32'd1};
        code[15*IW +: IW] = ins(2'b10, 2'd0, 4'd4);   // r0 -= ro0
        code[0*IW +: IW]  = ins(2'b01, 2'd1, 4'd5);   // r1 += ro1
        code[1*IW +: IW]  = ins(2'b01, 2'd1, 4'd13);  // r1 += (reads 0)
        code[14*IW +: IW] = ins(2'b01, 2'd2, 4'd6);   // must not execute
        code[2*IW +: IW]  = ins(2'b01, 2'd3, 4'd7);   // must not execute
        loop_addr[0 +: AW] = 4'd15;
        last_op[0 +: AW]   = 4'd2;
        push_beat(0, 0, 0, 32'hFFFF_FFFF, 32'd100, 1);
        start_prog();
        drain(-1, 0);

        // 5a. clear during RUN
        setup_two_loop();
        ready = 1'b0;
        start_prog();
        chk("run_busy", busy, 1);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        check_zero("clr_run");
        @(negedge clk);
        check_zero("clr_run2");

        // 5b. clear during HOLD, then rerun
        start_prog();
        wait_valid();
        chk("hold_offs", beat_if.offs, 128'd4);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        check_zero("clr_hold");
        push_two_loop();
        start_prog();
        drain(-1, 0);

        // 6a. start during HOLD is ignored
        push_two_loop();
        ready = 1'b0;
        start_prog();
        wait_valid();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        chk("ign_start_valid", beat_if.valid, 1);
        chk("ign_start_offs",  beat_if.offs, 128'd4);
        chk("ign_start_idx",   beat_if.idx,  0);
        drain(-1, 0);

        // 6b. single NOP, all ranges 0
        code = '0; loop_addr = '0; last_op = '0; range_v = '0;
        code[3*IW +: IW] = ins(2'b11, 2'd2, 4'd4);
        loop_addr[0 +: AW] = 4'd3;
        push_beat(0, 0, 0, 0, 0, 1);
        start_prog();
        drain(-1, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
`default_nettype wire
